bcd_to_binary_seq: RTL and testbench

- Parametrised sequential successor to the team's combinational BCD digit checker.
- Accepts a packed multi-digit BCD word over a valid/ready handshake and validates every nibble (>9 flagged and forced to 0).
- Converts the word to an unsigned binary integer iteratively, one digit per clock, most significant digit first.
- Presents the binary result plus a per-digit error mask on a valid/ready output handshake. Sits between BCD sources (keypad/display datapaths) and binary arithmetic blocks.

---
 rtl/bcd_to_binary_seq.sv | 127 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: accepts a packed multi-digit BCD word, sanitises each
// nibble (values above 9 are flagged and treated as 0), and converts it to an
// unsigned binary integer one digit per clock, most significant digit first.
// The result and a per-digit error mask are offered on a valid/ready output.
module bcd_to_binary_seq #(
   parameter int DIGITS = 8,
   parameter int BIN_W  = 27
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      out_bin,
   output logic [DIGITS-1:0]     out_digit_err,
   output logic                  out_err
);

   // Counter must be at least one bit wide even for a single-digit word.
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [4*DIGITS-1:0] bcd_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [BIN_W-1:0]    acc_reg;
   logic [DIGITS-1:0]   err_reg;

   logic [3:0]          digit_arr [DIGITS];
   logic [3:0]          cur_digit;
   logic                cur_bad;
   logic [3:0]          cur_clean;
   logic [BIN_W-1:0]    acc_next;
   logic                accept;

   // Split the captured word into individually addressable digits.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign digit_arr[gi] = bcd_reg[4*gi +: 4];
      end
   endgenerate

   // Digit currently being folded in; the counter walks from the MSD down.
   assign cur_digit = digit_arr[cnt_reg];
   assign cur_bad   = (cur_digit > 4'd9);
   assign cur_clean = cur_bad ? 4'd0 : cur_digit;

   // acc*10 built from two shifts; wraps modulo 2^BIN_W if BIN_W is undersized.
   assign acc_next = (acc_reg << 3) + (acc_reg << 1) + BIN_W'(cur_clean);

   assign accept = in_valid && (state_reg == IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = CONV;
            end
         end
         CONV: begin
            if (cnt_reg == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: capture on accept, accumulate one digit per CONV cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bcd_reg <= '0;
         cnt_reg <= '0;
         acc_reg <= '0;
         err_reg <= '0;
      end else if (accept) begin
         bcd_reg <= in_bcd;
         cnt_reg <= CNT_W'(DIGITS - 1);
         acc_reg <= '0;
         err_reg <= '0;
      end else if (state_reg == CONV) begin
         acc_reg <= acc_next;
         if (cur_bad) begin
            err_reg[cnt_reg] <= 1'b1;
         end
         if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end
      end
   end

   // Results come straight from the registers, so they hold outside DONE.
   assign out_bin       = acc_reg;
   assign out_digit_err = err_reg;
   assign out_err       = |err_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Testbench for bcd_to_binary_seq: table vectors, randomized words against a
// positional-value reference, and hand-written multi-cycle sequences.
module tb_bcd_to_binary_seq;

   localparam int DIGITS = 8;
   localparam int BIN_W  = 27;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [4*DIGITS-1:0] in_bcd = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [BIN_W-1:0]    out_bin;
   logic [DIGITS-1:0]   out_digit_err;
   logic                out_err;

   int errors = 0;
   int checks = 0;

   bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_bcd        (in_bcd),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_bin       (out_bin),
      .out_digit_err (out_digit_err),
      .out_err       (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bcd;
      logic [63:0] bin;
      logic [7:0]  err;
   } vec_t;

   // Reference value: sum of digit * 10^position, invalid digits count as 0.
   function automatic logic [63:0] ref_bin(input logic [31:0] w);
      longint unsigned sum;
      longint unsigned p;
      logic [3:0] nib;
      sum = 0;
      p   = 1;
      for (int k = 0; k < DIGITS; k++) begin
         nib = w[4*k +: 4];
         if (nib <= 4'd9) sum += longint'(nib) * p;
         p *= 10;
      end
      return sum % (64'd1 << BIN_W);
   endfunction

   function automatic logic [7:0] ref_err(input logic [31:0] w);
      logic [7:0] e;
      e = '0;
      for (int k = 0; k < DIGITS; k++) e[k] = (w[4*k +: 4] > 4'd9);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, wait for result, optional backpressure, transfer.
   task automatic run_word(input logic [31:0] w, input logic [63:0] exp_bin,
                           input logic [7:0] exp_err, input int hold);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) timeout("in_ready");
      in_valid = 1'b1;
      in_bcd   = w;
      tick();
      in_valid = 1'b0;
      in_bcd   = $urandom;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      if (!out_valid) timeout("out_valid");
      check("latency", 64'(n), 64'(DIGITS));
      check("out_bin", 64'(out_bin), exp_bin);
      check("out_digit_err", 64'(out_digit_err), 64'(exp_err));
      check("out_err", 64'(out_err), 64'(exp_err != 0));
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_bin", 64'(out_bin), exp_bin);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_valid", 64'(out_valid), 64'd0);
      check("post_in_ready", 64'(in_ready), 64'd1);
      $display("xfer bcd=%h bin=%0d err=%b", w, out_bin, out_digit_err);
   endtask

   vec_t vecs[7];
   logic [63:0] exp_q[$];
   logic [7:0]  err_q[$];

   initial begin
      logic [31:0] w;
      logic [63:0] eb;
      int last_acc;
      int n;

      vecs[0] = '{32'h12345678, 64'd12345678, 8'h00};
      vecs[1] = '{32'h99999999, 64'd99999999, 8'h00};
      vecs[2] = '{32'h00000000, 64'd0,        8'h00};
      vecs[3] = '{32'h12A4567F, 64'd12045670, 8'b0010_0001};
      vecs[4] = '{32'h00000042, 64'd42,       8'h00};
      vecs[5] = '{32'hFFFFFFFF, 64'd0,        8'hFF};
      vecs[6] = '{32'h9A000001, 64'd90000001, 8'b0100_0000};

      // Reset state.
      repeat (2) tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_bin", 64'(out_bin), 64'd0);
      check("rst_digit_err", 64'(out_digit_err), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      reset = 1'b1;
      tick();

      // Table vectors.
      for (int i = 0; i < 7; i++) run_word(vecs[i].bcd, vecs[i].bin, vecs[i].err, i % 2);

      // Randomized words, mostly valid digits with occasional invalid ones.
      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < DIGITS; k++)
            w[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 9));
         run_word(w, ref_bin(w), ref_err(w), $urandom_range(0, 3));
      end

      // Backpressure: hold DONE for 5 cycles while a new word is offered.
      w = 32'h87654321;
      in_valid = 1'b1;
      in_bcd   = w;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      if (!out_valid) timeout("bp_out_valid");
      in_valid = 1'b1;
      in_bcd   = 32'h11111111;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_bin", 64'(out_bin), 64'd87654321);
         check("bp_err", 64'(out_err), 64'd0);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_post_valid", 64'(out_valid), 64'd0);
      check("bp_post_ready", 64'(in_ready), 64'd1);
      check("bp_idle_hold", 64'(out_bin), 64'd87654321);
      $display("xfer bcd=%h bin=%0d backpressure", w, out_bin);

      // Reset asserted during the 4th CONV cycle.
      in_valid = 1'b1;
      in_bcd   = 32'h99999999;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      check("mid_rst_bin", 64'(out_bin), 64'd0);
      check("mid_rst_err", 64'(out_digit_err), 64'd0);
      reset = 1'b1;
      tick();
      check("mid_rst_quiet", 64'(out_valid), 64'd0);
      run_word(32'h00000042, 64'd42, 8'h00, 0);

      // Back-to-back with in_valid and out_ready held high.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_bcd    = $urandom;
      last_acc  = -1;
      for (int cyc = 0; cyc < 50; cyc++) begin
         logic acc_now;
         acc_now = in_ready;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               timeout("b2b_queue");
            end else begin
               eb = exp_q.pop_front();
               check("b2b_bin", 64'(out_bin), eb);
               check("b2b_err", 64'(out_digit_err), 64'(err_q.pop_front()));
               $display("xfer b2b bin=%0d", out_bin);
            end
         end
         if (acc_now) begin
            exp_q.push_back(ref_bin(in_bcd));
            err_q.push_back(ref_err(in_bcd));
            if (last_acc >= 0) check("b2b_interval", 64'(cyc - last_acc), 64'(DIGITS + 2));
            last_acc = cyc;
         end
         tick();
         if (acc_now) in_bcd = $urandom;
      end
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (out_valid) begin
            eb = exp_q.pop_front();
            check("b2b_drain_bin", 64'(out_bin), eb);
            check("b2b_drain_err", 64'(out_digit_err), 64'(err_q.pop_front()));
            $display("xfer b2b bin=%0d", out_bin);
         end
         tick();
         n++;
      end
      if (exp_q.size() != 0) timeout("b2b_drain");
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
